cq_manager: RTL and testbench
=============================

Name: cq_manager

Overview:
- Cyclic-queuing (CQF-style) buffer for a TSN egress port: two packet queues alternate between "receiving" and "transmitting" roles on a time-slice select.
- The upstream packet source writes bytes into the receiving queue; the transmission selector drains the other queue byte-by-byte on request.
- Sits between the ingress byte stream and the egress scheduler.

Parameters:
- DATA_W, 8, byte width of data_i/data_o.
- DEPTH, 1024, entries per queue (power of 2); one 1024-byte packet per slice.
- AW, log2(DEPTH)=10, address width (derived, localparam).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- fifo_sel_i  in  1  time-slice select: 0 = write Q0 / read Q1; 1 = write Q1 / read Q0.
- eop_i  in  1  marks the last byte of a packet, qualified by vld_i.
- vld_i  in  1  write-side byte valid.
- rdy_o  out  1  write-side ready (target queue not full).
- data_i  in  DATA_W  write byte.
- req_i  in  1  read request from scheduler.
- ack_o  out  1  read acknowledge; data_o valid this cycle.
- data_o  out  DATA_W  read byte.
- status_o  out  2  {Q1 non-empty, Q0 non-empty}.

Behaviour:
- Reset (rst_i=0, async): both queues empty, pointers and counters 0.
  - Outputs at reset: rdy_o=1, ack_o=0, data_o=0, status_o=2'b00.
  - Write-select latch = 0; in_pkt = 0.
- Queue storage: each entry is {eop, data} (DATA_W+1 bits); circular buffer.
  - Pointers are AW+1 bits; full = MSBs differ and low bits equal; empty = pointers equal.
- Write select latch (wsel):
  - Loaded from fifo_sel_i on any accepted byte when in_pkt=0.
  - in_pkt is set on an accepted non-eop byte and cleared on an accepted eop byte.
  - A packet therefore never splits across queues, even if fifo_sel_i toggles mid-packet.
  - Target queue = fifo_sel_i when in_pkt=0, wsel when in_pkt=1.
- Write handshake:
  - rdy_o = target queue not full (combinational).
  - Byte accepted when vld_i & rdy_o; stored at the next edge.
  - vld_i while rdy_o=0: byte not stored; source must hold it.
- Read side:
  - Source queue = ~fifo_sel_i (combinational, no latch).
  - When req_i=1, the source queue is non-empty, and the source queue is not the current write target: pop one entry.
  - Registered outputs: next cycle ack_o=1 and data_o=entry data (1-cycle latency).
  - Otherwise ack_o=0 and data_o holds its last value.
  - Continuous req_i gives one byte per cycle.
- Simultaneous write and read on different queues: independent.
  - The same queue is never both written and read: the read is blocked (ack_o=0) while the write target equals the read source, which happens only during a mid-packet slice switch.
- Slice switch (fifo_sel_i toggle): roles swap on the same cycle for reads, and at the packet boundary for writes.
  - Residual bytes in the old read queue remain and are drained in its next transmit slice.
- status_o: combinational from the empty flags, updated the cycle after each push/pop.

Optional Feature:
- Macro CQ_EOP_GATE_EN.
- Defined:
  - Each queue keeps a complete-packet counter (AW+1 bits): +1 on eop written, -1 on eop-tagged entry popped.
  - Reads are granted only if the source queue's packet count > 0, so partial packets are never transmitted.
  - status_o bits report packet count > 0 instead of non-empty.
- Undefined: no counters; any stored byte may be read.

Decomposition:
- Package cq_pkg: DATA_W, DEPTH, AW constants; queue-entry struct typedef {eop, data}; qid encoding (Q0=0, Q1=1).
- One sub-module cq_fifo: single-clock circular FIFO with push/pop, full/empty, and the optional packet counter.
  - Instantiated twice; the top holds the select latch, muxing, and read output registers.

Test Plan:
- Reset, then fifo_sel_i=0: write 1024 bytes 10..1033 (low 8 bits) with eop on the last.
  - Expect rdy_o=1 throughout and status_o=2'b01.
  - req_i=1 gives ack_o=0, because Q1 is empty.
- Toggle fifo_sel_i to 1, req_i=1.
  - Expect ack_o high for 1024 consecutive cycles starting 1 cycle after the toggle.
  - data_o sequence equals the bytes written, in order; status_o returns to 00 after the last byte (if Q1 is not being written).
- Concurrently with the previous scenario, write the inverted pattern (~cnt) to Q1.
  - Expect both streams to run at full rate with no loss; after the next toggle, Q1 drains the inverted bytes.
- Fill Q0 with 1025 writes and no reads.
  - Expect rdy_o=0 after 1024 entries; the 1025th byte is held, not stored.
  - After a toggle and one pop, rdy_o stays 0 for Q0 while Q0 is the read queue, and the new write target Q1 shows rdy_o=1.
- Toggle fifo_sel_i mid-packet (after 500 of 1024 bytes).
  - Expect the remaining 524 bytes still to go to the original queue.
  - Reads from that queue are blocked until eop is accepted.
- Assert rst_i=0 mid-transfer.
  - Expect ack_o=0, status_o=00, rdy_o=1 immediately.
  - Subsequent reads return nothing until new data is written.
  - With CQ_EOP_GATE_EN defined: a partial packet of 10 bytes without eop gives ack_o=0 until eop arrives.

Source files
------------

// File: rtl/cq_pkg.sv
// cq_pkg: shared constants and types for the cyclic-queuing buffer.
package cq_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH = 1024;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  typedef struct packed {
    logic              eop;
    logic [DATA_W-1:0] data;
  } cq_entry_t;
  typedef enum logic {Q0 = 1'b0, Q1 = 1'b1} qid_t;
endpackage

// File: rtl/cq_fifo.sv
// cq_fifo: single-clock circular FIFO of {eop, data} entries.
// With CQ_EOP_GATE_EN, avail_o means a complete packet is stored; otherwise non-empty.
module cq_fifo
  import cq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  cq_entry_t         wr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              avail_o
);
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  cq_entry_t r_mem [DEPTH];
  logic w_empty;
  assign w_empty = r_wr_ptr == r_rd_ptr;
  assign full_o = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign rd_data_o = r_mem[r_rd_ptr[AW-1:0]].data;
  always_ff @(posedge clk_i)
    if (push_i) r_mem[r_wr_ptr[AW-1:0]] <= wr_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop_i) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
`ifdef CQ_EOP_GATE_EN
  localparam int PW = AW + 1;
  logic [AW:0] r_pkt_cnt;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_pkt_cnt <= '0;
    else r_pkt_cnt <= r_pkt_cnt + PW'(push_i && wr_i.eop) - PW'(pop_i && r_mem[r_rd_ptr[AW-1:0]].eop);
  assign avail_o = !w_empty && (r_pkt_cnt != '0);
`else
  assign avail_o = !w_empty;
`endif
endmodule

// File: rtl/cq_manager.sv
// cq_manager: CQF buffer; two queues swap receive/transmit roles on fifo_sel_i.
// Define CQ_EOP_GATE_EN to transmit only complete packets.
module cq_manager
  import cq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fifo_sel_i,
  input  logic              eop_i,
  input  logic              vld_i,
  output logic              rdy_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              req_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        status_o
);
  qid_t r_wsel, w_tgt, w_src;
  logic r_in_pkt, r_ack, w_acc, w_rd_en;
  logic [DATA_W-1:0] r_data;
  logic [1:0] w_full, w_avail, w_push, w_pop;
  logic [DATA_W-1:0] w_rd [2];
  cq_entry_t w_wr;
  // writes stick to the latched queue until the packet's eop is accepted
  assign w_tgt = r_in_pkt ? r_wsel : qid_t'(fifo_sel_i);
  assign w_src = fifo_sel_i ? Q0 : Q1;
  assign rdy_o = !w_full[w_tgt];
  assign w_acc = vld_i && rdy_o;
  assign w_rd_en = req_i && w_avail[w_src] && (w_src != w_tgt);
  assign w_wr = '{eop: eop_i, data: data_i};
  assign w_push = {w_acc && (w_tgt == Q1), w_acc && (w_tgt == Q0)};
  assign w_pop = {w_rd_en && (w_src == Q1), w_rd_en && (w_src == Q0)};
  assign status_o = w_avail;
  assign ack_o = r_ack;
  assign data_o = r_data;
  for (genvar q = 0; q < 2; q++) begin : g_q
    cq_fifo u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (w_push[q]),
      .pop_i     (w_pop[q]),
      .wr_i      (w_wr),
      .rd_data_o (w_rd[q]),
      .full_o    (w_full[q]),
      .avail_o   (w_avail[q])
    );
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_ack <= 1'b0;
      r_data <= '0;
      r_in_pkt <= 1'b0;
      r_wsel <= Q0;
    end else begin
      r_ack <= w_rd_en;
      if (w_rd_en) r_data <= w_rd[w_src];
      if (w_acc) r_in_pkt <= !eop_i;
      if (w_acc && !r_in_pkt) r_wsel <= qid_t'(fifo_sel_i);
    end
endmodule

// File: tb/tb_cq_manager.sv
// tb_cq_manager: random and directed stimulus against a queue-based reference model.
module tb_cq_manager;
  import cq_pkg::*;
  logic clk_i = 1'b0, rst_i = 1'b0, fifo_sel_i = 1'b0, eop_i = 1'b0, vld_i = 1'b0, req_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic rdy_o, ack_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0] status_o;
  int checks = 0, failures = 0;
  logic [8:0] q0[$], q1[$];
  int pk [2];
  bit m_in_pkt, m_wsel, sel;
  logic [7:0] m_data, held;

  cq_manager dut (
    .clk_i(clk_i), .rst_i(rst_i), .fifo_sel_i(fifo_sel_i), .eop_i(eop_i), .vld_i(vld_i),
    .rdy_o(rdy_o), .data_i(data_i), .req_i(req_i), .ack_o(ack_o), .data_o(data_o),
    .status_o(status_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sz(input bit q);
    return q ? q1.size() : q0.size();
  endfunction

  function automatic bit avail(input bit q);
`ifdef CQ_EOP_GATE_EN
    return pk[q] > 0;
`else
    return sz(q) > 0;
`endif
  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    pk[0] = 0;
    pk[1] = 0;
    m_in_pkt = 0;
    m_wsel = 0;
    m_data = '0;
  endfunction

  // one cycle: drive at posedge+1, check combinational outputs at negedge, registered ones after the edge
  task automatic step(input bit s, input bit vld, input bit eop, input logic [7:0] d, input bit req);
    bit tgt, src, er, acc, gnt;
    logic [8:0] v;
    fifo_sel_i = s;
    vld_i = vld;
    eop_i = eop;
    data_i = d;
    req_i = req;
    tgt = m_in_pkt ? m_wsel : s;
    src = !s;
    er = sz(tgt) < DEPTH;
    acc = vld && er;
    gnt = req && (src != tgt) && avail(src);
    @(negedge clk_i);
    check("rdy", rdy_o, er);
    check("status", status_o, {avail(1), avail(0)});
    @(posedge clk_i);
    #1;
    if (gnt) begin
      v = src ? q1.pop_front() : q0.pop_front();
      m_data = v[7:0];
      if (v[8]) pk[src]--;
    end
    if (acc) begin
      if (tgt) q1.push_back({eop, d});
      else q0.push_back({eop, d});
      if (eop) pk[tgt]++;
      if (!m_in_pkt) m_wsel = s;
      m_in_pkt = !eop;
    end
    check("ack", ack_o, gnt);
    check("data", data_o, m_data);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rdy", rdy_o, 1);
    check("rst_ack", ack_o, 0);
    check("rst_data", data_o, 0);
    check("rst_status", status_o, 0);
    rst_i = 1'b1;
    for (int i = 0; i < 1024; i++) step(0, 1, i == 1023, 8'(i + 10), 1);
    for (int i = 0; i < 1024; i++) step(1, 1, i == 1023, ~8'(i), 1);
    for (int i = 0; i < 1025; i++) begin
      held = 8'($urandom);
      step(0, 1, i >= 1023, held, 1);
    end
    step(1, 1, 1, held, 1);
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (1030) step(1, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 1024; i++) step(i < 500 ? 1'b0 : 1'b1, 1, i == 1023, 8'(i), 1);
    repeat (1030) step(1, 0, 0, 0, 1);
    sel = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) sel = !sel;
      step(sel, $urandom_range(1) == 1, $urandom_range(19) == 0, 8'($urandom), $urandom_range(3) != 0);
    end
    rst_i = 1'b0;
    #1;
    check("arst_ack", ack_o, 0);
    check("arst_status", status_o, 0);
    check("arst_rdy", rdy_o, 1);
    check("arst_data", data_o, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (4) step(1, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'(i + 100), 0);
    repeat (5) step(1, 0, 0, 0, 1);
    step(1, 1, 1, 8'hAA, 1);
    repeat (15) step(1, 0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
